reset_sequencer: RTL and testbench

- Parametrised system reset controller; successor to the fixed 8-clock power-on shift register and the hard-wired AND of reset sources in the board top.
- Synchronises and debounces NSRC active-low reset requests (keyboard reset, buttons, etc.) and stretches every reset event to a minimum length.
- Releases NOUT staged reset outputs in order: core first, then peripherals, then video.
- Records the cause of the last reset and keeps a saturating reset count for the LEDs.

---
 rtl/reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged system reset controller: request sync/debounce, stretch, ordered release, cause and count.
// Optional watchdog built in when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer #(
   parameter int              NSRC       = 3,
   parameter int              NOUT       = 2,
   parameter int              POR_CYCLES = 8,
   parameter int              STRETCH    = 16,
   parameter int              STAGE_GAP  = 4,
   parameter logic [NSRC-1:0] DEB_MASK   = 3'b100,
   parameter int              DEB_CYCLES = 1024,
   parameter int              WDT_CYCLES = 65536
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] req_n,
   input  logic            wdt_kick,
   output logic [NOUT-1:0] rst_n,
   output logic            busy,
   output logic [NSRC+1:0] cause,
   output logic [7:0]      reset_count
);

   localparam int CNT_MAX0 = (POR_CYCLES > STRETCH) ? POR_CYCLES : STRETCH;
   localparam int CNT_MAX  = (CNT_MAX0 > STAGE_GAP) ? CNT_MAX0 : STAGE_GAP;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int DEB_W    = $clog2(DEB_CYCLES + 1);

   if (STAGE_GAP == 0) begin : g_bad_gap
      $error("reset_sequencer: STAGE_GAP must be nonzero");
   end

   typedef enum logic [1:0] {S_POR, S_ASSERT, S_RELEASE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NOUT-1:0]   rst_q, rst_d;
   logic [NSRC+1:0]   cause_q, cause_d;
   logic [7:0]        count_q, count_d;
   logic [NSRC-1:0]   sync1_q, sync2_q, filt;
   logic [NSRC-1:0]   req_act;
   logic              act;
   logic              wdt_fire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= req_n;
         sync2_q <= sync1_q;
      end
   end

   // Mechanical inputs only change the filtered level after DEB_CYCLES stable cycles.
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      if (DEB_MASK[i]) begin : g_deb
         logic [DEB_W-1:0] deb_q;
         logic             filt_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               deb_q  <= '0;
               filt_q <= 1'b1;
            end else if (sync2_q[i] == filt_q) begin
               deb_q  <= '0;
            end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
               deb_q  <= '0;
               filt_q <= sync2_q[i];
            end else begin
               deb_q  <= deb_q + 1'b1;
            end
         end
         assign filt[i] = filt_q;
      end else begin : g_raw
         assign filt[i] = sync2_q[i];
      end
   end

   assign req_act = ~filt;
   assign act     = |req_act;

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0] wdt_q;
   assign wdt_fire = (state_q == S_RUN) && (wdt_q == WDT_W'(WDT_CYCLES - 1));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wdt_q <= '0;
      else if (state_q != S_RUN || wdt_kick || wdt_fire)
         wdt_q <= '0;
      else
         wdt_q <= wdt_q + 1'b1;
   end
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick ^ WDT_CYCLES[0];
   assign wdt_fire   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         S_POR: begin
            cause_d[NSRC-1:0] = cause_q[NSRC-1:0] | req_act;
            if (cnt_q == CNT_W'(POR_CYCLES - 1)) begin
               state_d = S_ASSERT;
               cnt_d   = CNT_W'(STRETCH);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ASSERT: begin
            cause_d[NSRC-1:0] = cause_q[NSRC-1:0] | req_act;
            if (act) begin
               cnt_d = CNT_W'(STRETCH);
            end else if (cnt_q <= CNT_W'(1)) begin
               // Entering RELEASE on the cycle the count hits zero frees rst_n[0] immediately.
               state_d = S_RELEASE;
               cnt_d   = '0;
               rst_d   = NOUT'(1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (act || wdt_fire) begin
               state_d = S_ASSERT;
               cnt_d   = CNT_W'(STRETCH);
               rst_d   = '0;
               cause_d = act ? {2'b00, req_act} : {2'b10, {NSRC{1'b0}}};
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end else if (state_q == S_RELEASE) begin
               if (&rst_q) begin
                  state_d = S_RUN;
               end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                  // Released outputs form a thermometer code; shift in the next one.
                  cnt_d = '0;
                  rst_d = NOUT'({rst_q, 1'b1});
                  if (&rst_d) state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_POR;
         cnt_q   <= '0;
         rst_q   <= '0;
         cause_q <= {2'b01, {NSRC{1'b0}}};
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         cause_q <= cause_d;
         count_q <= count_d;
      end
   end

   assign rst_n       = rst_q;
   assign busy        = (state_q != S_RUN);
   assign cause       = cause_q;
   assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer (default parameters, WDT_CYCLES=64).
module tb_reset_sequencer;

   localparam int NSRC = 3;
   localparam int NOUT = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSRC-1:0] req_n;
   logic            wdt_kick;
   logic [NOUT-1:0] rst_n;
   logic            busy;
   logic [NSRC+1:0] cause;
   logic [7:0]      reset_count;

   int total = 0;
   int bad   = 0;
   bit seen;

   reset_sequencer #(.WDT_CYCLES(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_n       (req_n),
      .wdt_kick    (wdt_kick),
      .rst_n       (rst_n),
      .busy        (busy),
      .cause       (cause),
      .reset_count (reset_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NSRC-1:0] m);
      req_n = ~m;
      step();
      req_n = '1;
   endtask

   task automatic wait_run(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      check(tag, 32'(busy), 32'h0);
   endtask

   initial begin
      reset = 1'b0;
      req_n = '1;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_kick = 1'b1;
`else
      wdt_kick = 1'b0;
`endif
      step(5);
      check("por_rst", 32'(rst_n), 32'h0);
      check("por_busy", 32'(busy), 32'h1);
      check("por_cause", 32'(cause), 32'h08);
      check("por_count", 32'(reset_count), 32'h0);

      reset = 1'b1;
      step(23);
      check("pwr_c23", 32'(rst_n), 32'h0);
      step();
      check("pwr_c24", 32'(rst_n), 32'h1);
      check("pwr_c24_busy", 32'(busy), 32'h1);
      step(3);
      check("pwr_c27", 32'(rst_n), 32'h1);
      step();
      check("pwr_c28", 32'(rst_n), 32'h3);
      check("pwr_c28_busy", 32'(busy), 32'h0);
      check("pwr_cause", 32'(cause), 32'h08);
      check("pwr_count", 32'(reset_count), 32'h0);

      // Single-cycle request on an undebounced input.
      pulse(3'b001);
      step();
      check("req0_p2", 32'(rst_n), 32'h3);
      step();
      check("req0_p3", 32'(rst_n), 32'h0);
      check("req0_busy", 32'(busy), 32'h1);
      step(15);
      check("req0_hold", 32'(rst_n), 32'h0);
      step();
      check("req0_rel0", 32'(rst_n), 32'h1);
      step(4);
      check("req0_rel1", 32'(rst_n), 32'h3);
      check("req0_cause", 32'(cause), 32'h01);
      check("req0_count", 32'(reset_count), 32'h1);

      // Short glitch on the debounced input must be filtered out.
      seen  = 1'b0;
      req_n = 3'b011;
      for (int i = 0; i < 1600; i++) begin
         if (i == 500) req_n = '1;
         step();
         if (rst_n != 2'b11) seen = 1'b1;
      end
      check("glitch_noreset", 32'(seen), 32'h0);
      check("glitch_count", 32'(reset_count), 32'h1);

      // Held press on the debounced input.
      req_n = 3'b011;
      step(1026);
      check("deb_pre", 32'(rst_n), 32'h3);
      step();
      check("deb_hit", 32'(rst_n), 32'h0);
      check("deb_cause", 32'(cause), 32'h04);
      check("deb_count", 32'(reset_count), 32'h2);
      step(973);
      req_n = '1;
      wait_run("deb_run", 2000);
      check("deb_cause_run", 32'(cause), 32'h04);

      // Re-request while stages are still being released.
      pulse(3'b001);
      step(18);
      check("rr_rel0", 32'(rst_n), 32'h1);
      pulse(3'b001);
      check("rr_e1", 32'(rst_n), 32'h1);
      step();
      check("rr_e2", 32'(rst_n), 32'h1);
      step();
      check("rr_e3", 32'(rst_n), 32'h0);
      check("rr_count", 32'(reset_count), 32'h4);
      step(15);
      check("rr_hold", 32'(rst_n), 32'h0);
      step();
      check("rr_rel0b", 32'(rst_n), 32'h1);
      step(4);
      check("rr_rel1", 32'(rst_n), 32'h3);
      check("rr_cause", 32'(cause), 32'h01);

      // Simultaneous requests.
      pulse(3'b011);
      step(2);
      wait_run("sim_run", 100);
      check("sim_cause", 32'(cause), 32'h03);
      check("sim_count", 32'(reset_count), 32'h5);

      // Counter saturation.
      for (int i = 0; i < 300; i++) begin
         pulse(3'b010);
         step(2);
         wait_run("sat_run", 100);
         if (i == 248) check("sat_254", 32'(reset_count), 32'hFE);
      end
      check("sat_255", 32'(reset_count), 32'hFF);
      check("sat_cause", 32'(cause), 32'h02);

`ifdef RESET_SEQ_WATCHDOG_EN
      for (int i = 0; i < 6; i++) begin
         wdt_kick = 1'b0;
         step(31);
         wdt_kick = 1'b1;
         step();
      end
      check("wdt_kicked", 32'(busy), 32'h0);
      wdt_kick = 1'b0;
      step(63);
      check("wdt_pre", 32'(rst_n), 32'h3);
      step();
      check("wdt_hit", 32'(rst_n), 32'h0);
      check("wdt_cause", 32'(cause), 32'h10);
      check("wdt_count", 32'(reset_count), 32'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
